// File: rtl/mem_io_responder.sv
// Responder for the CPU byte bus: muxes block-RAM read data with a small I/O space
// (input FIFO, output FIFO, cycle counter, stop flag) at mem_a[17:16] == 2'b11.
module mem_io_responder #(
  parameter int IN_AW  = 4,
  parameter int OUT_AW = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  input  logic [7:0]  ram_dout,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        prog_stop,
  output logic        tx_overflow
);

  localparam int IN_DEPTH  = 1 << IN_AW;
  localparam int OUT_DEPTH = 1 << OUT_AW;

  logic        io;
  logic [15:0] off;
  logic        cpu_rd;
  logic        cpu_wr;
  logic        unused_addr;

  assign io          = (mem_a[17:16] == 2'b11);
  assign off         = mem_a[15:0];
  assign cpu_rd      = rdy_in & ~mem_wr;
  assign cpu_wr      = rdy_in & mem_wr;
  assign unused_addr = ^mem_a[31:18];

  // Host handshakes: a byte moves on a rising edge where valid && ready are both
  // high; ready never depends on valid, and neither side depends on rdy_in.

  // ---------------- input FIFO (host -> CPU) ----------------
  logic [7:0]     in_mem [IN_DEPTH];
  logic [IN_AW:0] in_wp;
  logic [IN_AW:0] in_rp;
  logic           in_empty;
  logic           in_full;
  logic           in_push;
  logic           in_pop;

  assign in_empty = (in_wp == in_rp);
  assign in_full  = (in_wp[IN_AW] != in_rp[IN_AW]) &&
                    (in_wp[IN_AW-1:0] == in_rp[IN_AW-1:0]);
  assign rx_ready = ~in_full;
  assign in_push  = rx_valid & rx_ready;
  assign in_pop   = cpu_rd & io & (off == 16'h0000) & ~in_empty;

  always_ff @(posedge clk_in) begin
    if (in_push) in_mem[in_wp[IN_AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      in_wp <= '0;
      in_rp <= '0;
    end else begin
      if (in_push) in_wp <= in_wp + 1'b1;
      if (in_pop)  in_rp <= in_rp + 1'b1;
    end
  end

  // ---------------- output FIFO (CPU -> host) ----------------
  logic [7:0]      out_mem [OUT_DEPTH];
  logic [OUT_AW:0] out_wp;
  logic [OUT_AW:0] out_rp;
  logic            out_empty;
  logic            out_full;
  logic            out_pop;
  logic            out_push_req;
  logic            out_push;
  logic            out_drop;
  logic [7:0]      out_push_data;
  logic            stop_wr;

  assign out_empty     = (out_wp == out_rp);
  assign out_full      = (out_wp[OUT_AW] != out_rp[OUT_AW]) &&
                         (out_wp[OUT_AW-1:0] == out_rp[OUT_AW-1:0]);
  assign tx_valid      = ~out_empty;
  assign tx_data       = out_empty ? 8'h00 : out_mem[out_rp[OUT_AW-1:0]];
  assign out_pop       = tx_valid & tx_ready;
  assign stop_wr       = cpu_wr & io & (off == 16'h0004);
  // The stop marker is a literal 0x00, so it skips the zero filter on data writes.
  assign out_push_req  = stop_wr |
                         (cpu_wr & io & (off == 16'h0000) & (mem_dout != 8'h00));
  assign out_push_data = stop_wr ? 8'h00 : mem_dout;
  // A full FIFO still takes the byte when the host frees the head slot this cycle.
  assign out_push      = out_push_req & (~out_full | out_pop);
  assign out_drop      = out_push_req & out_full & ~out_pop;

  always_ff @(posedge clk_in) begin
    if (out_push) out_mem[out_wp[OUT_AW-1:0]] <= out_push_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      out_wp <= '0;
      out_rp <= '0;
    end else begin
      if (out_push) out_wp <= out_wp + 1'b1;
      if (out_pop)  out_rp <= out_rp + 1'b1;
    end
  end

  // ---------------- counter, snapshot and read path ----------------
  logic [31:0] cnt;
  logic [31:0] cnt_snap;
  logic [7:0]  io_rdata;
  logic        sel_ram_q;
  logic [7:0]  io_q;
  logic        frozen_q;
  logic [7:0]  hold_q;

  always_comb begin
    io_rdata = 8'h00;
    case (off)
      16'h0000: io_rdata = in_empty ? 8'h00 : in_mem[in_rp[IN_AW-1:0]];
      16'h0004: io_rdata = cnt[7:0];
      16'h0005: io_rdata = cnt_snap[15:8];
      16'h0006: io_rdata = cnt_snap[23:16];
      16'h0007: io_rdata = cnt_snap[31:24];
      default:  io_rdata = 8'h00;
    endcase
  end

  // While stalled, RAM data may follow a changing address, so the last visible
  // byte is parked in hold_q; reset starts parked at 0x00.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sel_ram_q   <= 1'b1;
      io_q        <= 8'h00;
      frozen_q    <= 1'b1;
      hold_q      <= 8'h00;
      cnt         <= '0;
      cnt_snap    <= '0;
      prog_stop   <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      frozen_q <= ~rdy_in;
      if (!rdy_in) hold_q <= mem_din;
      if (rdy_in) begin
        cnt <= cnt + 32'd1;
        if (cpu_rd) begin
          sel_ram_q <= ~io;
          io_q      <= io ? io_rdata : 8'h00;
        end
        if (cpu_rd && io && (off == 16'h0004)) cnt_snap <= cnt;
        if (stop_wr)  prog_stop   <= 1'b1;
        if (out_drop) tx_overflow <= 1'b1;
      end
    end
  end

  assign mem_din = frozen_q ? hold_q : (sel_ram_q ? ram_dout : io_q);

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: per-cycle driver with a reference model and an
// expected-read queue, feature tasks called in order from one initial block.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic [31:0] mem_a = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = '0;
  logic [7:0]  mem_din;
  logic [7:0]  ram_dout = '0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        prog_stop;
  logic        tx_overflow;

  mem_io_responder #(.IN_AW(4), .OUT_AW(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .ram_dout(ram_dout),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .prog_stop(prog_stop), .tx_overflow(tx_overflow)
  );

  // ---------------- clock / RAM stand-in ----------------
  always #5 clk_in = ~clk_in;

  // Synchronous RAM with a recognisable per-address pattern.
  always @(posedge clk_in) ram_dout <= mem_a[7:0] ^ 8'h5A;

  // ---------------- scoreboard / model state ----------------
  int          n_tests;
  int          n_fail;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_m[$];
  logic [7:0]  tx_m[$];
  logic [31:0] m_cnt;
  logic [31:0] m_snap;
  logic        m_stop;
  logic        m_ovf;
  logic        rd_pend;
  logic        m_frozen;
  logic        m_hold_valid;
  logic [7:0]  last_din;

  task automatic model_clear();
    exp_q.delete();
    rx_m.delete();
    tx_m.delete();
    m_cnt        = '0;
    m_snap       = '0;
    m_stop       = 1'b0;
    m_ovf        = 1'b0;
    rd_pend      = 1'b0;
    m_frozen     = 1'b1;
    m_hold_valid = 1'b1;
    last_din     = 8'h00;
  endtask

  // One bus cycle: check what the previous edge produced, drive the next cycle,
  // check the host-side output, then advance the model across the coming edge.
  task automatic step(input logic wr, input logic [31:0] a, input logic [7:0] d,
                      input logic rdy, input logic rxv, input logic [7:0] rxd,
                      input logic txr);
    logic [7:0]  e;
    logic [15:0] off;
    logic        io;
    logic        pop_now;
    logic        rx_full_pre;
    int          tx_size_pre;
    @(negedge clk_in);
    if (rd_pend) begin
      e = exp_q.pop_front();
      last_din = e;
      n_tests++;
      if (mem_din !== e) begin
        n_fail++;
        $display("FAIL read_data: mem_din=%h expected=%h", mem_din, e);
      end
    end else if (m_frozen && m_hold_valid) begin
      n_tests++;
      if (mem_din !== last_din) begin
        n_fail++;
        $display("FAIL read_hold: mem_din=%h expected=%h", mem_din, last_din);
      end
    end
    n_tests++;
    if (prog_stop !== m_stop) begin
      n_fail++;
      $display("FAIL prog_stop: got=%b expected=%b", prog_stop, m_stop);
    end
    n_tests++;
    if (tx_overflow !== m_ovf) begin
      n_fail++;
      $display("FAIL tx_overflow: got=%b expected=%b", tx_overflow, m_ovf);
    end
    mem_wr = wr; mem_a = a; mem_dout = d; rdy_in = rdy;
    rx_valid = rxv; rx_data = rxd; tx_ready = txr;
    #1;
    n_tests++;
    if (tx_valid !== (tx_m.size() != 0)) begin
      n_fail++;
      $display("FAIL tx_valid: got=%b expected=%b", tx_valid, tx_m.size() != 0);
    end
    n_tests++;
    if (rx_ready !== (rx_m.size() < 16)) begin
      n_fail++;
      $display("FAIL rx_ready: got=%b expected=%b", rx_ready, rx_m.size() < 16);
    end
    pop_now = txr && (tx_m.size() != 0);
    if (pop_now) begin
      n_tests++;
      if (tx_data !== tx_m[0]) begin
        n_fail++;
        $display("FAIL tx_data: got=%h expected=%h", tx_data, tx_m[0]);
      end
    end
    io          = (a[17:16] == 2'b11);
    off         = a[15:0];
    rx_full_pre = (rx_m.size() >= 16);
    tx_size_pre = tx_m.size();
    if (rdy && !wr) begin
      e = 8'h00;
      if (!io) e = a[7:0] ^ 8'h5A;
      else begin
        case (off)
          16'h0000: if (rx_m.size() != 0) e = rx_m.pop_front();
          16'h0004: begin m_snap = m_cnt; e = m_cnt[7:0]; end
          16'h0005: e = m_snap[15:8];
          16'h0006: e = m_snap[23:16];
          16'h0007: e = m_snap[31:24];
          default:  e = 8'h00;
        endcase
      end
      exp_q.push_back(e);
      m_hold_valid = 1'b1;
    end
    if (rdy && wr) m_hold_valid = 1'b0;
    rd_pend  = rdy && !wr;
    m_frozen = !rdy;
    if (rxv && !rx_full_pre) rx_m.push_back(rxd);
    if (pop_now) void'(tx_m.pop_front());
    if (rdy && wr && io && (((off == 16'h0000) && (d != 8'h00)) || (off == 16'h0004))) begin
      if (tx_size_pre < 16 || pop_now) tx_m.push_back((off == 16'h0004) ? 8'h00 : d);
      else m_ovf = 1'b1;
      if (off == 16'h0004) m_stop = 1'b1;
    end
    if (rdy) m_cnt = m_cnt + 32'd1;
  endtask

  task automatic idle(input logic txr);
    step(1'b1, 32'h0, 8'h00, 1'b1, 1'b0, 8'h00, txr);
  endtask

  task automatic cpu_read(input logic [31:0] a);
    step(1'b0, a, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests++;
    if (mem_din !== 8'h00 || tx_valid !== 1'b0 || tx_data !== 8'h00 ||
        rx_ready !== 1'b1 || prog_stop !== 1'b0 || tx_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: din=%h txv=%b txd=%h rxr=%b stop=%b ovf=%b expected 00 0 00 1 0 0",
               tag, mem_din, tx_valid, tx_data, rx_ready, prog_stop, tx_overflow);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    check_reset_outputs("reset_values");
    @(negedge clk_in);
    rst_in = 1'b1;
    cpu_read(32'h0003_0000);
    idle(1'b0);
  endtask

  task automatic test_ram_read();
    logic [31:0] a;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      if (a[17:16] == 2'b11) a[17] = 1'b0;
      cpu_read(a);
    end
    cpu_read(32'h0003_0008);
    cpu_read(32'h0003_FFFF);
    cpu_read(32'h0002_0005);
    idle(1'b0);
  endtask

  task automatic test_rx_fifo();
    step(1'b1, 32'h0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0);
    step(1'b1, 32'h0, 8'h00, 1'b1, 1'b1, 8'h42, 1'b0);
    cpu_read(32'h0003_0000);
    cpu_read(32'h0003_0000);
    cpu_read(32'hABC3_0000);
    // Pop and push in the same cycle on an empty FIFO.
    step(1'b0, 32'h0003_0000, 8'h00, 1'b1, 1'b1, 8'h77, 1'b0);
    cpu_read(32'h0003_0000);
    for (int i = 0; i < 17; i++)
      step(1'b1, 32'h0, 8'h00, 1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 17; i++) cpu_read(32'h0003_0000);
    idle(1'b0);
  endtask

  task automatic test_tx();
    step(1'b1, 32'h0003_0000, 8'h48, 1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 32'h0003_0000, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 32'h0003_0000, 8'h69, 1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 32'h0003_0001, 8'h33, 1'b1, 1'b0, 8'h00, 1'b1);
    repeat (3) idle(1'b1);
  endtask

  task automatic test_counter();
    repeat (300) idle(1'b0);
    cpu_read(32'h0003_0004);
    cpu_read(32'h0003_0005);
    cpu_read(32'h0003_0006);
    cpu_read(32'h0003_0007);
    idle(1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++)
      step(1'b1, 32'h0003_0000, 8'($urandom_range(1, 255)), 1'b1, 1'b0, 8'h00, 1'b0);
    idle(1'b0);
    n_tests++;
    if (tx_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: tx_overflow=%b expected=1", tx_overflow);
    end
    step(1'b1, 32'h0003_0004, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0);
    idle(1'b0);
    n_tests++;
    if (prog_stop !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_set: prog_stop=%b expected=1", prog_stop);
    end
    // Full FIFO with a simultaneous host pop: the push must be accepted.
    step(1'b1, 32'h0003_0000, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1);
    repeat (17) idle(1'b1);
  endtask

  task automatic test_rdy_hold();
    step(1'b1, 32'h0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0);
    step(1'b1, 32'h0003_0000, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0);
    cpu_read(32'h0000_0123);
    for (int i = 0; i < 10; i++)
      step(1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 255)),
           1'b0, 1'b0, 8'h00, 1'b0);
    cpu_read(32'h0003_0004);
    idle(1'b0);
    @(negedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_clear();
    rdy_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    cpu_read(32'h0003_0000);
    idle(1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_clear();
    test_reset();
    test_ram_read();
    test_rx_fifo();
    test_tx();
    test_counter();
    test_overflow();
    test_rdy_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
